// File: rtl/seg_scan_decoder.sv
// Recovers hex digits from a multiplexed 4-digit 7-segment scan by waiting for a
// stable scan window, then decoding the active digit's segment pattern.
module seg_scan_decoder #(
   parameter int STABLE_CYCLES  = 4,
   parameter int TIMEOUT_CYCLES = 1048576
) (
   input  logic       clk_in,
   input  logic       rst,
   input  logic [3:0] dig,
   input  logic [6:0] seg_n,
   output logic [3:0] digit0,
   output logic [3:0] digit1,
   output logic [3:0] digit2,
   output logic [3:0] digit3,
   output logic [3:0] digit_valid,
   output logic       frame_done,
   output logic       seg_err,
   output logic       stale
);

   localparam int IW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [7:0]    STAB_EVAL = 8'(STABLE_CYCLES - 2);
   localparam logic [7:0]    STAB_MAX  = 8'(STABLE_CYCLES - 1);
   localparam logic [IW-1:0] IDLE_LAST = IW'(TIMEOUT_CYCLES - 1);
   localparam logic [IW-1:0] IDLE_SAT  = IW'(TIMEOUT_CYCLES);

   logic [10:0]   samp;
   logic [10:0]   held;
   logic [7:0]    stab_cnt;
   logic [IW-1:0] idle_cnt;
   logic [3:0]    digit_r [4];
   logic [3:0]    seen;

   logic          eval;
   logic          one_hot;
   logic [1:0]    idx;
   logic          dec_ok;
   logic [3:0]    dec_val;
   logic [6:0]    lit;
   logic [3:0]    samp_dig;
   logic [3:0]    seen_next;

   assign samp_dig  = samp[10:7];
   assign lit       = ~samp[6:0];
   assign seen_next = seen | samp_dig;

   assign digit0 = digit_r[0];
   assign digit1 = digit_r[1];
   assign digit2 = digit_r[2];
   assign digit3 = digit_r[3];

   // Evaluation fires on the one edge where the stability count steps onto its
   // saturation value, so a held window is judged exactly once.
   assign eval = (samp == held) && (stab_cnt == STAB_EVAL);

   always_comb begin
      one_hot = 1'b1;
      idx     = 2'd0;
      case (samp_dig)
         4'b0001: idx = 2'd0;
         4'b0010: idx = 2'd1;
         4'b0100: idx = 2'd2;
         4'b1000: idx = 2'd3;
         default: one_hot = 1'b0;
      endcase
   end

   always_comb begin
      dec_ok  = 1'b1;
      dec_val = 4'h0;
      case (lit)
         7'b1111110: dec_val = 4'h0;
         7'b0110000: dec_val = 4'h1;
         7'b1101101: dec_val = 4'h2;
         7'b1111001: dec_val = 4'h3;
         7'b0110011: dec_val = 4'h4;
         7'b1011011: dec_val = 4'h5;
         7'b1011111: dec_val = 4'h6;
         7'b1110000: dec_val = 4'h7;
         7'b1111111: dec_val = 4'h8;
         7'b1111011: dec_val = 4'h9;
         7'b1110111: dec_val = 4'hA;
         7'b0011111: dec_val = 4'hB;
         7'b1001110: dec_val = 4'hC;
         7'b0111101: dec_val = 4'hD;
         7'b1001111: dec_val = 4'hE;
         7'b1000111: dec_val = 4'hF;
         default:    dec_ok  = 1'b0;
      endcase
   end

   always_ff @(posedge clk_in or posedge rst) begin
      if (rst) begin
         samp     <= '0;
         held     <= '0;
         stab_cnt <= '0;
      end else begin
         samp <= {dig, seg_n};
         held <= samp;
         if (samp != held)
            stab_cnt <= '0;
         else if (stab_cnt != STAB_MAX)
            stab_cnt <= stab_cnt + 8'd1;
      end
   end

   // A successful capture takes priority over the timeout on the same edge; the
   // idle counter parks one past the expiry value so stale pulses only once.
   always_ff @(posedge clk_in or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 4; i++) digit_r[i] <= '0;
         digit_valid <= '0;
         seen        <= '0;
         idle_cnt    <= '0;
         frame_done  <= 1'b0;
         seg_err     <= 1'b0;
         stale       <= 1'b0;
      end else begin
         frame_done <= 1'b0;
         seg_err    <= 1'b0;
         stale      <= 1'b0;
         if (eval && one_hot && dec_ok) begin
            digit_r[idx] <= dec_val;
            digit_valid  <= digit_valid | samp_dig;
            idle_cnt     <= '0;
            if (seen_next == 4'b1111) begin
               frame_done <= 1'b1;
               seen       <= '0;
            end else begin
               seen <= seen_next;
            end
         end else begin
            if (eval && one_hot) begin
               seg_err     <= 1'b1;
               digit_valid <= digit_valid & ~samp_dig;
            end
            if (idle_cnt == IDLE_LAST) begin
               stale       <= 1'b1;
               digit_valid <= '0;
               seen        <= '0;
               idle_cnt    <= IDLE_SAT;
            end else if (idle_cnt != IDLE_SAT) begin
               idle_cnt <= idle_cnt + IW'(1);
            end
         end
      end
   end

endmodule
